// File: rtl/avalon_pio_pkg.sv
// avalon_pio_pkg: register offsets and edge-type selectors for the extended PIO port
package avalon_pio_pkg;
  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_DIR     = 3'd1;
  localparam logic [2:0] ADDR_IRQMASK = 3'd2;
  localparam logic [2:0] ADDR_EDGECAP = 3'd3;
  localparam logic [2:0] ADDR_OUTSET  = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR  = 3'd5;
  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;
endpackage

// File: rtl/pio_edge_sync.sv
// pio_edge_sync: pin synchroniser, previous-sample register, arm counter and edge detect
module pio_edge_sync
  import avalon_pio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = EDGE_RISE
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] in_sync,
  output logic [WIDTH-1:0] det
);
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] prev_q;
  logic [2:0] arm_q;
  logic armed;
  logic [WIDTH-1:0] rise, fall;
  assign armed   = arm_q == 3'(SYNC_STAGES + 1);
  assign in_sync = sync_q[SYNC_STAGES-1];
  assign rise    = in_sync & ~prev_q;
  assign fall    = ~in_sync & prev_q;
  // Edges are suppressed until the chain has filled with real pin samples after reset
  assign det     = !armed ? '0 :
                   EDGE_TYPE == EDGE_RISE ? rise :
                   EDGE_TYPE == EDGE_FALL ? fall : (rise | fall);
  // Shift pins through the synchroniser, remember the last synced value, count up to armed
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      prev_q <= '0;
      arm_q  <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in_port};
      prev_q <= in_sync;
      arm_q  <= armed ? arm_q : arm_q + 3'd1;
    end
  end
endmodule

// File: rtl/avalon_pio_ext.sv
// avalon_pio_ext: Avalon-MM GPIO slave with direction, set/clear writes, edge capture and irq
module avalon_pio_ext
  import avalon_pio_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] OUT_RESET   = '0,
  parameter logic [WIDTH-1:0] DIR_RESET   = '0,
  parameter int               SYNC_STAGES = 2,
  parameter int               EDGE_TYPE   = EDGE_RISE
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] out_oe,
  output logic             irq
);
  logic [WIDTH-1:0] out_q, out_d, dir_q, dir_d, mask_q, mask_d, cap_q, cap_d;
  logic [WIDTH-1:0] in_sync, det, wd, clr, rd;
  logic wr, unused_wd;
  pio_edge_sync #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES), .EDGE_TYPE(EDGE_TYPE)) u_sync (
    .clk(clk), .reset_n(reset_n), .in_port(in_port), .in_sync(in_sync), .det(det)
  );
  assign unused_wd = ^writedata;
  assign wr        = chipselect & ~write_n;
  assign wd        = writedata[WIDTH-1:0];
  assign out_port  = out_q;
  assign out_oe    = dir_q;
  assign irq       = |(cap_q & mask_q);
  // Next-state of the register file; a fresh edge beats a same-cycle W1C on the same bit
  always_comb begin
    out_d  = !wr ? out_q :
             address == ADDR_DATA   ? wd :
             address == ADDR_OUTSET ? (out_q | wd) :
             address == ADDR_OUTCLR ? (out_q & ~wd) : out_q;
    dir_d  = (wr && address == ADDR_DIR) ? wd : dir_q;
    mask_d = (wr && address == ADDR_IRQMASK) ? wd : mask_q;
    clr    = (wr && address == ADDR_EDGECAP) ? wd : '0;
    cap_d  = (cap_q & ~clr) | det;
  end
  // Side-effect-free read mux; output pins read back the driven value, inputs the synced pin
  always_comb begin
    rd = address == ADDR_DATA    ? ((out_q & dir_q) | (in_sync & ~dir_q)) :
         address == ADDR_DIR     ? dir_q :
         address == ADDR_IRQMASK ? mask_q :
         address == ADDR_EDGECAP ? cap_q : '0;
    readdata = 32'(rd);
  end
  // Register file state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_q  <= OUT_RESET;
      dir_q  <= DIR_RESET;
      mask_q <= '0;
      cap_q  <= '0;
    end else begin
      out_q  <= out_d;
      dir_q  <= dir_d;
      mask_q <= mask_d;
      cap_q  <= cap_d;
    end
  end
endmodule
